// File: rtl/alu_pkg.sv
// Shared ALU operation encoding and RV32I opcode constants for decode and execute.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9,
    AluEq   = 4'd10
  } alu_op_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] Funct7Zero = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  // funct3 -> ALU op; alt selects SUB/SRA on the two encodings that have an alternate form.
  function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I integer decode: ALU op, operand sources, immediate, rd, legality.
module id_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [3:0]  alu_op,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic [31:0] a_const,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  // Decode; operands not sourced from rs1/rs2 come from a_const / imm.
  always_comb begin
    alu_op  = AluAdd;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    a_const = '0;
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OpcOp: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        alu_op  = alu_op_from_funct3(funct3, funct7[5]);
        if (funct7 == Funct7Alt) begin
          illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if (funct7 != Funct7Zero) begin
          illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        use_rs1 = 1'b1;
        imm     = {{20{instr[31]}}, instr[31:20]};
        // funct7[5] is immediate data here except on right shifts
        alu_op  = alu_op_from_funct3(funct3, 1'b0);
        if (funct3 == 3'b001) begin
          imm     = {27'b0, instr[24:20]};
          illegal = (funct7 != Funct7Zero);
        end else if (funct3 == 3'b101) begin
          imm     = {27'b0, instr[24:20]};
          alu_op  = funct7[5] ? AluSra : AluSrl;
          illegal = (funct7 != Funct7Zero) && (funct7 != Funct7Alt);
        end
      end
      OpcLui: begin
        imm = {instr[31:12], 12'b0};
      end
      OpcAuipc: begin
        a_const = pc;
        imm     = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    // Illegal instructions issue as a harmless ADD 0,0 with no sources
    if (illegal) begin
      alu_op  = AluAdd;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      a_const = '0;
      imm     = '0;
    end
  end

  assign wb_en = !illegal && (rd != 5'd0);

endmodule

// File: rtl/id_stage.sv
// Decode stage: operand bypass, register scoreboard and the decode-to-ALU output register.
module id_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  logic [3:0]  dec_alu_op;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic [31:0] dec_a_const;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_wb_en;
  logic        dec_illegal;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hazard;
  logic        accept;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_a_q, out_a_d;
  logic [31:0] out_b_q, out_b_d;
  logic [3:0]  out_alu_op_q, out_alu_op_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_wb_en_q, out_wb_en_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_illegal_q, out_illegal_d;
  logic [31:0] busy_q, busy_d;

  id_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .alu_op  (dec_alu_op),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2),
    .a_const (dec_a_const),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .wb_en   (dec_wb_en),
    .illegal (dec_illegal)
  );

  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  // Operand read with writeback bypass; x0 always reads zero.
  always_comb begin
    rs1_val = rf_rdata1;
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end else if (wb_valid && (wb_rd == rs1)) begin
      rs1_val = wb_data;
    end
    rs2_val = rf_rdata2;
    if (rs2 == 5'd0) begin
      rs2_val = '0;
    end else if (wb_valid && (wb_rd == rs2)) begin
      rs2_val = wb_data;
    end
    op_a = dec_use_rs1 ? rs1_val : dec_a_const;
    op_b = dec_use_rs2 ? rs2_val : dec_imm;
  end

  // RAW hazard: a used source is still pending and not being retired this cycle.
  always_comb begin
    hazard = 1'b0;
    if (dec_use_rs1 && (rs1 != 5'd0) && busy_q[rs1] && !(wb_valid && (wb_rd == rs1))) begin
      hazard = 1'b1;
    end
    if (dec_use_rs2 && (rs2 != 5'd0) && busy_q[rs2] && !(wb_valid && (wb_rd == rs2))) begin
      hazard = 1'b1;
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Next-state for output register and scoreboard; a set on accept overrides a same-rd clear.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_alu_op_d  = out_alu_op_q;
    out_rd_d      = out_rd_q;
    out_wb_en_d   = out_wb_en_q;
    out_pc_d      = out_pc_q;
    out_illegal_d = out_illegal_q;
    busy_d        = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end
    // A flushed entry will never retire, so release its destination
    if (flush && out_valid_q && out_wb_en_q) begin
      busy_d[out_rd_q] = 1'b0;
    end
    if (accept) begin
      out_valid_d   = 1'b1;
      out_a_d       = op_a;
      out_b_d       = op_b;
      out_alu_op_d  = dec_alu_op;
      out_rd_d      = dec_rd;
      out_wb_en_d   = dec_wb_en;
      out_pc_d      = in_pc;
      out_illegal_d = dec_illegal;
      if (dec_wb_en) begin
        busy_d[dec_rd] = 1'b1;
      end
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_alu_op_q  <= AluAdd;
      out_rd_q      <= '0;
      out_wb_en_q   <= 1'b0;
      out_pc_q      <= '0;
      out_illegal_q <= 1'b0;
      busy_q        <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_alu_op_q  <= out_alu_op_d;
      out_rd_q      <= out_rd_d;
      out_wb_en_q   <= out_wb_en_d;
      out_pc_q      <= out_pc_d;
      out_illegal_q <= out_illegal_d;
      busy_q        <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_alu_op  = out_alu_op_q;
  assign out_rd      = out_rd_q;
  assign out_wb_en   = out_wb_en_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes hand-computed results, monitor pops on transfer.
module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [31:0] out_pc;
  logic        out_illegal;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_xfer = 0;

  id_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_op  (out_alu_op),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                              input logic [3:0] op, input logic [4:0] rd, input logic wb,
                              input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.pc = pc; e.op = op; e.rd = rd; e.wb = wb; e.ill = ill;
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    rf_rdata1 = d1;
    rf_rdata2 = d2;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2, input exp_t e,
                       input bit push);
    bit ok;
    ok = 1'b0;
    drive(instr, pc, d1, d2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_accept_timeout"}, {31'b0, in_ready}, 32'd1);
    else if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  // Monitor: every completed transfer must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mon_unexpected: got pc 0x%08h, want no transfer", out_pc);
      end else begin
        e = sb.pop_front();
        check($sformatf("xfer%0d_a", n_xfer), out_a, e.a);
        check($sformatf("xfer%0d_b", n_xfer), out_b, e.b);
        check($sformatf("xfer%0d_pc", n_xfer), out_pc, e.pc);
        check($sformatf("xfer%0d_op", n_xfer), {28'b0, out_alu_op}, {28'b0, e.op});
        check($sformatf("xfer%0d_rd", n_xfer), {27'b0, out_rd}, {27'b0, e.rd});
        check($sformatf("xfer%0d_wb", n_xfer), {31'b0, out_wb_en}, {31'b0, e.wb});
        check($sformatf("xfer%0d_ill", n_xfer), {31'b0, out_illegal}, {31'b0, e.ill});
        n_xfer++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_alu_op", {28'b0, out_alu_op}, 32'd0);
    check("rst_out_rd", {27'b0, out_rd}, 32'd0);
    check("rst_wb_en", {31'b0, out_wb_en}, 32'd0);
    check("rst_illegal", {31'b0, out_illegal}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI x1,x0,5: rs1=x0 must read 0 despite junk read data
    issue("addi_x1", 32'h0050_0093, 32'h100, 32'h1234_5678, 32'hdead_beef,
          mk(32'd0, 32'd5, 32'h100, 4'd0, 5'd1, 1'b1, 1'b0), 1'b1);
    // ADD x2,x1,x1 waits on busy x1
    drive(32'h0010_8133, 32'h104, 32'hdead_0001, 32'hdead_0002);
    @(negedge clk);
    check("addi_latency_valid", {31'b0, out_valid}, 32'd1);
    check("hazard_x1_c0", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hazard_x1_c1", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
    @(negedge clk);
    check("bypass_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(mk(32'd7, 32'd7, 32'h104, 4'd0, 5'd2, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    wb_valid = 1'b0; in_valid = 1'b0;

    // Stall ADD x2 for three cycles with SRAI x3,x4,31 pending
    out_ready = 1'b0;
    drive(32'h41F2_5193, 32'h108, 32'h8000_0000, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
      check($sformatf("stall%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("stall%0d_a", i), out_a, 32'd7);
      check($sformatf("stall%0d_b", i), out_b, 32'd7);
      check($sformatf("stall%0d_rd", i), {27'b0, out_rd}, 32'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue("srai_x3", 32'h41F2_5193, 32'h108, 32'h8000_0000, 32'h5555_5555,
          mk(32'h8000_0000, 32'd31, 32'h108, 4'd7, 5'd3, 1'b1, 1'b0), 1'b1);
    #1;
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_op_sra", {28'b0, out_alu_op}, 32'd7);
    #1;
    issue("sub_x5", 32'h4073_02B3, 32'h10c, 32'd100, 32'd30,
          mk(32'd100, 32'd30, 32'h10c, 4'd1, 5'd5, 1'b1, 1'b0), 1'b1);
    issue("illegal_opc", 32'h0000_007F, 32'h110, 32'hffff_ffff, 32'hffff_ffff,
          mk(32'd0, 32'd0, 32'h110, 4'd0, 5'd0, 1'b0, 1'b1), 1'b1);
    issue("illegal_f7", 32'h0200_0033, 32'h114, 32'hffff_ffff, 32'hffff_ffff,
          mk(32'd0, 32'd0, 32'h114, 4'd0, 5'd0, 1'b0, 1'b1), 1'b1);
    issue("addi_neg", 32'hFFF0_8493, 32'h118, 32'h10, 32'hffff_ffff,
          mk(32'h10, 32'hffff_ffff, 32'h118, 4'd0, 5'd9, 1'b1, 1'b0), 1'b1);
    issue("auipc_x10", 32'h1234_5517, 32'h1000, 32'hffff_ffff, 32'hffff_ffff,
          mk(32'h1000, 32'h1234_5000, 32'h1000, 4'd0, 5'd10, 1'b1, 1'b0), 1'b1);
    drain();

    // Flush a held LUI x8; its dependent must then issue
    out_ready = 1'b0;
    issue("lui_x8", 32'hABCD_E437, 32'h200, 32'h0, 32'h0,
          mk(32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0), 1'b0);
    drive(32'h0014_0593, 32'h300, 32'h55, 32'h0);
    @(negedge clk);
    check("lui_held_valid", {31'b0, out_valid}, 32'd1);
    check("lui_a", out_a, 32'd0);
    check("lui_b", out_b, 32'hABCD_E000);
    check("lui_wb_en", {31'b0, out_wb_en}, 32'd1);
    check("hazard_x8", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_clears_valid", {31'b0, out_valid}, 32'd0);
    check("flush_clears_busy_x8", {31'b0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(mk(32'h55, 32'd1, 32'h300, 4'd0, 5'd11, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset while an entry is held
    out_ready = 1'b0;
    issue("addi_x12", 32'h0030_0613, 32'h400, 32'h0, 32'h0,
          mk(32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_b", out_b, 32'd0);
    check("async_rst_rd", {27'b0, out_rd}, 32'd0);
    out_ready = 1'b1;
    drive(32'h0006_0693, 32'h404, 32'h99, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(mk(32'h99, 32'd0, 32'h404, 4'd0, 5'd13, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_first_edge", {31'b0, out_valid}, 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
